// File: rtl/pb_debounce_pkg.sv
// ---------------------------------------------------------------------------
// pb_debounce_pkg
// Shared definitions for the multi-channel push-button debouncer:
//   - pb_state_t : per-channel debounce FSM state, 3-bit encoding
//   - cnt_width  : width needed for a counter that must hold 0..max_val
// ---------------------------------------------------------------------------
package pb_debounce_pkg;

  typedef enum logic [2:0] {
    PB_IDLE      = 3'd0,
    PB_CNT_PRESS = 3'd1,
    PB_PRESSED   = 3'd2,
    PB_STABLE    = 3'd3,
    PB_CNT_REL   = 3'd4,
    PB_RELEASED  = 3'd5
  } pb_state_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pb_debouncer_multi_if.sv
// ---------------------------------------------------------------------------
// pb_debouncer_multi_if
// Bundles the button pins and the debounced outputs of pb_debouncer_multi.
//   i_pb             : raw asynchronous button inputs (board side)
//   o_status         : debounced level, 1 = pressed
//   o_pressed_pulse  : 1-cycle pulse on an accepted press
//   o_released_pulse : 1-cycle pulse on an accepted release
//   o_long_pulse     : 1-cycle pulse on a long press (0 when feature is off)
// Modports: master = the side that drives the pins and consumes the events,
//           slave  = the debouncer itself.
// ---------------------------------------------------------------------------
interface pb_debouncer_multi_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] i_pb;
  logic [N_CH-1:0] o_status;
  logic [N_CH-1:0] o_pressed_pulse;
  logic [N_CH-1:0] o_released_pulse;
  logic [N_CH-1:0] o_long_pulse;

  modport master (
    output i_pb,
    input  o_status,
    input  o_pressed_pulse,
    input  o_released_pulse,
    input  o_long_pulse
  );

  modport slave (
    input  i_pb,
    output o_status,
    output o_pressed_pulse,
    output o_released_pulse,
    output o_long_pulse
  );
endinterface

// File: rtl/pb_debounce_ch.sv
// ---------------------------------------------------------------------------
// pb_debounce_ch
// One debounce channel: 2-FF synchroniser, optional polarity inversion,
// press/release debounce FSM with a shared stability counter, and (when
// PB_LONG_PRESS_EN is defined) a saturating long-press counter.
// Ports:
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_pb               : raw asynchronous button pin
//   o_status           : debounced level, 1 = pressed
//   o_pressed_pulse    : 1-cycle pulse on accepted press
//   o_released_pulse   : 1-cycle pulse on accepted release
//   o_long_pulse       : 1-cycle pulse after LONG_DELAY cycles held
// Macro: PB_LONG_PRESS_EN enables the long-press counter.
// All outputs are flops fed from the registered state, so they are glitch-free
// and appear one cycle after the FSM enters PRESSED/RELEASED.
// ---------------------------------------------------------------------------
module pb_debounce_ch
  import pb_debounce_pkg::*;
#(
  parameter int DELAY      = 15,
  parameter int LONG_DELAY = 1000,
  parameter bit INVERT     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pb,
  output logic o_status,
  output logic o_pressed_pulse,
  output logic o_released_pulse,
  output logic o_long_pulse
);

  if (DELAY < 2) begin : g_bad_delay
    $error("pb_debounce_ch: DELAY must be >= 2");
  end
  if (LONG_DELAY < 1) begin : g_bad_long
    $error("pb_debounce_ch: LONG_DELAY must be >= 1");
  end

  localparam int CW = cnt_width(DELAY);
  localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);

  logic [1:0]    sync_q, sync_d;
  pb_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          status_q, status_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          pb_s;
  logic          counting;

  always_comb begin
    sync_d   = {sync_q[0], i_pb};
    pb_s     = sync_q[1] ^ INVERT;
    state_d  = state_q;
    case (state_q)
      PB_IDLE:      if (pb_s) state_d = PB_CNT_PRESS;
      PB_CNT_PRESS: if (!pb_s) state_d = PB_IDLE;
                    else if (cnt_q >= CNT_LAST) state_d = PB_PRESSED;
      PB_PRESSED:   state_d = PB_STABLE;
      PB_STABLE:    if (!pb_s) state_d = PB_CNT_REL;
      PB_CNT_REL:   if (pb_s) state_d = PB_STABLE;
                    else if (cnt_q >= CNT_LAST) state_d = PB_RELEASED;
      PB_RELEASED:  state_d = PB_IDLE;
      default:      state_d = PB_IDLE;
    endcase
    // Counter only runs while the FSM stays in a counting state; any state
    // change restarts the stability window from zero.
    counting = (state_q == PB_CNT_PRESS) || (state_q == PB_CNT_REL);
    cnt_d    = (counting && (state_d == state_q)) ? cnt_q + 1'b1 : '0;
    status_d = (state_q == PB_PRESSED) || (state_q == PB_STABLE) ||
               (state_q == PB_CNT_REL);
    press_d  = (state_q == PB_PRESSED);
    rel_d    = (state_q == PB_RELEASED);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // Synchroniser resets to the pin's idle level so the channel comes out
      // of reset reading "not pressed" regardless of polarity.
      sync_q   <= {2{INVERT}};
      state_q  <= PB_IDLE;
      cnt_q    <= '0;
      status_q <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
    end
  end

  assign o_status         = status_q;
  assign o_pressed_pulse  = press_q;
  assign o_released_pulse = rel_q;

`ifdef PB_LONG_PRESS_EN
  localparam int LW = cnt_width(LONG_DELAY);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_DELAY);
  localparam logic [LW-1:0] LONG_PRE = LW'(LONG_DELAY - 1);

  logic [LW-1:0] long_cnt_q, long_cnt_d;
  logic          long_q, long_d;
  logic          held;

  always_comb begin
    held       = (state_q == PB_STABLE) || (state_q == PB_CNT_REL);
    long_cnt_d = long_cnt_q;
    long_d     = 1'b0;
    if (state_q == PB_IDLE) begin
      long_cnt_d = '0;
    end else if (held && (long_cnt_q != LONG_MAX)) begin
      // Saturating at LONG_MAX guarantees a single long pulse per press.
      long_cnt_d = long_cnt_q + 1'b1;
      long_d     = (long_cnt_q == LONG_PRE);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      long_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      long_cnt_q <= long_cnt_d;
      long_q     <= long_d;
    end
  end

  assign o_long_pulse = long_q;
`else
  assign o_long_pulse = 1'b0;
`endif

endmodule

// File: rtl/pb_debouncer_multi.sv
// ---------------------------------------------------------------------------
// pb_debouncer_multi
// N_CH independent push-button debouncers between board pins and control
// FSMs. Every output is synchronous to i_clk.
// Ports:
//   i_clk : clock
//   i_rst : synchronous, active-high reset
//   bus   : pb_debouncer_multi_if.slave (i_pb in; o_status, o_pressed_pulse,
//           o_released_pulse, o_long_pulse out; all N_CH wide)
// Parameters: N_CH channels, DELAY stability cycles, ACTIVE_LOW pin polarity,
//             LONG_DELAY long-press cycles.
// Macro: PB_LONG_PRESS_EN enables o_long_pulse; otherwise it is tied to 0.
// ---------------------------------------------------------------------------
module pb_debouncer_multi
  import pb_debounce_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DELAY      = 15,
  parameter int ACTIVE_LOW = 0,
  parameter int LONG_DELAY = 1000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  pb_debouncer_multi_if.slave   bus
);

  if (N_CH < 1) begin : g_bad_nch
    $error("pb_debouncer_multi: N_CH must be >= 1");
  end

  // Polarity is applied per channel after its synchroniser.
  localparam bit INVERT = (ACTIVE_LOW != 0);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pb_debounce_ch #(
      .DELAY      (DELAY),
      .LONG_DELAY (LONG_DELAY),
      .INVERT     (INVERT)
    ) u_ch (
      .i_clk            (i_clk),
      .i_rst            (i_rst),
      .i_pb             (bus.i_pb[i]),
      .o_status         (bus.o_status[i]),
      .o_pressed_pulse  (bus.o_pressed_pulse[i]),
      .o_released_pulse (bus.o_released_pulse[i]),
      .o_long_pulse     (bus.o_long_pulse[i])
    );
  end

endmodule

// File: tb/tb_pb_debouncer_multi.sv
// ---------------------------------------------------------------------------
// tb_pb_debouncer_multi
// Directed bench for pb_debouncer_multi with N_CH=2, DELAY=4, LONG_DELAY=10.
// dut0 uses active-high pins, dut1 active-low pins; both share clock/reset.
// An input change applied just after a clock edge is sampled by the next
// edge (edge 0); its pulse is visible just after edge DELAY+3, i.e. on the
// (DELAY+4)-th step.
// ---------------------------------------------------------------------------
module tb_pb_debouncer_multi;

  localparam int N_CH       = 2;
  localparam int DELAY      = 4;
  localparam int LONG_DELAY = 10;
  localparam int LAT        = DELAY + 3;
`ifdef PB_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pb_debouncer_multi_if #(.N_CH(N_CH)) bus0 ();
  pb_debouncer_multi_if #(.N_CH(N_CH)) bus1 ();

  pb_debouncer_multi #(
    .N_CH(N_CH), .DELAY(DELAY), .ACTIVE_LOW(0), .LONG_DELAY(LONG_DELAY)
  ) dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus0)
  );

  pb_debouncer_multi #(
    .N_CH(N_CH), .DELAY(DELAY), .ACTIVE_LOW(1), .LONG_DELAY(LONG_DELAY)
  ) dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // sel: 0 status, 1 pressed, 2 released, 3 long
  function automatic logic [1:0] get(input int d, input int sel);
    logic [1:0] v;
    v = 2'b00;
    if (d == 0) begin
      case (sel)
        0: v = bus0.o_status;
        1: v = bus0.o_pressed_pulse;
        2: v = bus0.o_released_pulse;
        default: v = bus0.o_long_pulse;
      endcase
    end else begin
      case (sel)
        0: v = bus1.o_status;
        1: v = bus1.o_pressed_pulse;
        2: v = bus1.o_released_pulse;
        default: v = bus1.o_long_pulse;
      endcase
    end
    return v;
  endfunction

  // Pulse must stay low for LAT steps and be exactly 'mask' on step LAT+1.
  task automatic expect_pulse(input string tag, input int d, input int sel,
                              input logic [1:0] mask);
    for (int i = 1; i <= LAT + 1; i++) begin
      step();
      chk(tag, get(d, sel), (i == LAT + 1) ? mask : 2'b00);
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus0.i_pb = 2'b00;
    bus1.i_pb = 2'b11;
    repeat (3) step();
    for (int s = 0; s < 4; s++) begin
      chk("reset_dut0", get(0, s), 2'b00);
      chk("reset_dut1", get(1, s), 2'b00);
    end
    rst = 1'b0;
    repeat (4) step();
    chk("idle_dut1_status", get(1, 0), 2'b00);
    chk("idle_dut1_press", get(1, 1), 2'b00);

    // Clean press and release on ch0; ch1 stays quiet.
    bus0.i_pb = 2'b01;
    expect_pulse("press_clean", 0, 1, 2'b01);
    chk("status_rise", get(0, 0), 2'b01);
    step();
    chk("press_one_cycle", get(0, 1), 2'b00);
    chk("status_held", get(0, 0), 2'b01);
    bus0.i_pb = 2'b00;
    expect_pulse("release_clean", 0, 2, 2'b01);
    chk("status_fall", get(0, 0), 2'b00);
    step();
    chk("release_one_cycle", get(0, 2), 2'b00);
    repeat (2) step();

    // Press bounce: 1,0,1,0 for 2 cycles each, then held 1.
    for (int k = 0; k < 4; k++) begin
      bus0.i_pb = (k % 2 == 0) ? 2'b01 : 2'b00;
      repeat (2) begin
        step();
        chk("bounce_no_press", get(0, 1), 2'b00);
        chk("bounce_status", get(0, 0), 2'b00);
      end
    end
    bus0.i_pb = 2'b01;
    expect_pulse("press_after_bounce", 0, 1, 2'b01);

    // Release bounce: 0 for 3 cycles, 1 for 1 cycle, then held 0.
    bus0.i_pb = 2'b00;
    repeat (3) begin
      step();
      chk("rel_glitch_status", get(0, 0), 2'b01);
      chk("rel_glitch_no_rel", get(0, 2), 2'b00);
    end
    bus0.i_pb = 2'b01;
    step();
    chk("rel_glitch_status", get(0, 0), 2'b01);
    bus0.i_pb = 2'b00;
    expect_pulse("release_after_bounce", 0, 2, 2'b01);
    chk("status_after_bounce", get(0, 0), 2'b00);
    repeat (3) step();

    // Active-low, both channels together.
    bus1.i_pb = 2'b00;
    expect_pulse("al_press_both", 1, 1, 2'b11);
    chk("al_status_both", get(1, 0), 2'b11);
    repeat (2) step();
    bus1.i_pb = 2'b11;
    expect_pulse("al_release_both", 1, 2, 2'b11);
    chk("al_status_clear", get(1, 0), 2'b00);
    repeat (2) step();

    // Reset while ch0 is in CNT_PRESS with cnt=2, input kept high.
    bus0.i_pb = 2'b01;
    repeat (5) step();
    chk("pre_reset_no_press", get(0, 1), 2'b00);
    rst = 1'b1;
    repeat (2) begin
      step();
      chk("in_reset_press", get(0, 1), 2'b00);
      chk("in_reset_status", get(0, 0), 2'b00);
    end
    rst = 1'b0;
    expect_pulse("press_after_reset", 0, 1, 2'b01);
    chk("status_after_reset", get(0, 0), 2'b01);
    bus0.i_pb = 2'b00;
    expect_pulse("release_after_reset", 0, 2, 2'b01);
    repeat (3) step();

    // Long hold: 30 cycles after the press pulse.
    bus0.i_pb = 2'b01;
    expect_pulse("press_long", 0, 1, 2'b01);
    for (int i = 1; i <= 30; i++) begin
      step();
      chk("long_hold", get(0, 3), (LONG_EN && i == LONG_DELAY) ? 2'b01 : 2'b00);
    end
    bus0.i_pb = 2'b00;
    expect_pulse("release_long", 0, 2, 2'b01);
    repeat (3) step();

    // Short hold: released before LONG_DELAY, no long pulse.
    bus0.i_pb = 2'b01;
    expect_pulse("press_short", 0, 1, 2'b01);
    bus0.i_pb = 2'b00;
    for (int i = 1; i <= LAT + 3; i++) begin
      step();
      chk("short_no_long", get(0, 3), 2'b00);
      chk("short_release", get(0, 2), (i == LAT + 1) ? 2'b01 : 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
